// File: rtl/pwm_pkg.sv
// Shared constants and types for the switch-driven PWM duty ramp block.
package pwm_pkg;

  localparam int unsigned DUTY_W        = 4;
  localparam int unsigned DB_BITS_DEF   = 16;
  localparam int unsigned STEP_BITS_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } ramp_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer and stability filter for the duty-request switch bank.
// Produces the accepted target code and a one-cycle pulse after each accepted change.
module sw_debounce
  import pwm_pkg::*;
#(
  parameter int unsigned DB_BITS = DB_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] sw_raw,
  output logic [DUTY_W-1:0] sw_stable,
  output logic              stable_pulse
);

  logic [DUTY_W-1:0]  r_sync1;
  logic [DUTY_W-1:0]  r_sync2;
  logic [DUTY_W-1:0]  r_cand;
  logic [DUTY_W-1:0]  r_target;
  logic [DB_BITS-1:0] r_db_cnt;
  logic               r_pulse;
  logic               w_accept;

  // A candidate is accepted only after the counter has saturated on it.
  assign w_accept = (r_db_cnt == '1) && (r_cand != r_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_target <= '0;
      r_db_cnt <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand   <= r_sync2;
        r_db_cnt <= '0;
      end else if (r_db_cnt != '1) begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      if (w_accept) begin
        r_target <= r_cand;
      end
      r_pulse <= w_accept;
    end
  end

  assign sw_stable    = r_target;
  assign stable_pulse = r_pulse;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Debounced switch bank to PWM duty code. With PWM_RAMP_EN defined the duty code
// walks toward the target one LSB per 2**STEP_BITS cycles; otherwise it jumps.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned DB_BITS   = DB_BITS_DEF,
  parameter int unsigned STEP_BITS = STEP_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] sw,
  output logic [DUTY_W-1:0] duty,
  output logic              busy
);

  if (DB_BITS < 1 || STEP_BITS < 1) begin : g_bad_param
    $error("pwm_duty_ramp: DB_BITS and STEP_BITS must be at least 1");
  end

  logic [DUTY_W-1:0] w_target;
  logic              w_tgt_upd;
  logic [DUTY_W-1:0] r_duty;
  logic              r_busy;

  sw_debounce #(
    .DB_BITS (DB_BITS)
  ) u_sw_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_raw       (sw),
    .sw_stable    (w_target),
    .stable_pulse (w_tgt_upd)
  );

`ifdef PWM_RAMP_EN
  ramp_state_t          r_state;
  ramp_state_t          w_state_nxt;
  logic [STEP_BITS-1:0] r_step_tmr;
  logic                 w_inc;
  logic                 w_dec;

  // Direction comes straight from the registered compare, so a step can never
  // carry duty past a target that moved underneath it.
  always_comb begin
    w_state_nxt = IDLE;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    if (w_target > r_duty) begin
      w_state_nxt = UP;
    end else if (w_target < r_duty) begin
      w_state_nxt = DOWN;
    end
    if (r_step_tmr == '1) begin
      w_inc = (w_state_nxt == UP);
      w_dec = (w_state_nxt == DOWN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_step_tmr <= '0;
      r_duty     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      // Timer keeps running across UP<->DOWN reversals; only IDLE clears it.
      if (w_state_nxt == IDLE) begin
        r_step_tmr <= '0;
      end else begin
        r_step_tmr <= r_step_tmr + 1'b1;
      end
      if (w_inc) begin
        r_duty <= r_duty + 1'b1;
      end else if (w_dec) begin
        r_duty <= r_duty - 1'b1;
      end
    end
  end

  a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_inc && r_duty == '1) && !(w_dec && r_duty == '0));

  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
    r_busy == (r_state != IDLE));
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_tgt_upd) begin
        r_duty <= w_target;
      end
      r_busy <= (r_duty != w_target);
    end
  end
`endif

  assign duty = r_duty;
  assign busy = r_busy;

endmodule
